// File: rtl/xgs_spi_pkg.sv
// Shared definitions for the XGS SPI responder.
//   spi_state_t : responder FSM states
//   ADDR_W_DEF / DATA_W_DEF / RD_WAIT_MAX_DEF : default widths and read wait
//   CMD_RNW_BIT : position of the read/not-write flag in the command word
package xgs_spi_pkg;

    localparam int ADDR_W_DEF      = 15;
    localparam int DATA_W_DEF      = 16;
    localparam int RD_WAIT_MAX_DEF = 4;
    localparam int CMD_RNW_BIT     = 0;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_FETCH,
        RD_DATA
    } spi_state_t;

endpackage

// File: rtl/xgs_spi_sync.sv
// Two-flop synchronizer for the three SPI pins plus an edge register for
// CSn and SCLK.
//   sys_clk             : system clock
//   csn_pin/sclk_pin/mosi_pin : raw asynchronous SPI pins
//   csn_rise/csn_fall   : one-cycle CSn edge pulses
//   sclk_rise/sclk_fall : one-cycle SCLK edge pulses
//   mosi                : synchronized MOSI level, aligned with sclk_rise
module xgs_spi_sync (
    input  logic sys_clk,
    input  logic csn_pin,
    input  logic sclk_pin,
    input  logic mosi_pin,
    output logic csn_rise,
    output logic csn_fall,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic mosi
);

    logic [2:0] meta;
    logic [2:0] sync;
    logic [1:0] prev;

    // Deliberately not reset: a sys_reset in the middle of a frame must not
    // turn the still-low CSn into a fresh falling edge afterwards.
    always_ff @(posedge sys_clk) begin
        meta <= {mosi_pin, sclk_pin, csn_pin};
        sync <= meta;
        prev <= sync[1:0];
    end

    assign csn_rise  =  sync[0] & ~prev[0];
    assign csn_fall  = ~sync[0] &  prev[0];
    assign sclk_rise =  sync[1] & ~prev[1];
    assign sclk_fall = ~sync[1] &  prev[1];
    assign mosi      =  sync[2];

endmodule

// File: rtl/xgs_spi_responder.sv
// Sensor-side SPI (mode 0) responder: decodes {addr, rnw} command words and
// data words into single-cycle register-file write/read requests and shifts
// read data back on MISO.
// Build option: XGS_SPI_RESP_BURST_EN enables multi-word frames with address
// auto-increment (wrapping); without it only the first data word of a frame
// is acted upon and later SCLK edges are ignored.
// Ports:
//   sys_clk, sys_reset            : clock, synchronous active-high reset
//   spi_csn_i/sclk_i/mosi_i       : SPI pins (asynchronous)
//   spi_miso_o, spi_miso_oe_o     : MISO data and output enable
//   reg_addr_o, reg_wr_o, reg_wdata_o, reg_rd_o : register-file requests
//   reg_rdata_i, reg_rvalid_i     : register-file read return
//   spi_err_o                     : one-cycle protocol error pulse
//
// state    | meaning
// IDLE     | waiting for CSn fall
// CMD      | shifting in the {addr, rnw} command word
// WR_DATA  | shifting in write data words
// RD_FETCH | read requested, waiting for reg_rvalid_i or timeout
// RD_DATA  | shifting read data out on MISO
module xgs_spi_responder
    import xgs_spi_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RD_WAIT_MAX = RD_WAIT_MAX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              spi_csn_i,
    input  logic              spi_sclk_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic              reg_wr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              reg_rd_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    input  logic              reg_rvalid_i,
    output logic              spi_err_o
);

    localparam int CMD_W = ADDR_W + 1;
    localparam int SH_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W = $clog2(SH_W);
    localparam int TMR_W = $clog2(RD_WAIT_MAX + 1);
`ifdef XGS_SPI_RESP_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic csn_rise, csn_fall, sclk_rise, sclk_fall, mosi;

    xgs_spi_sync u_sync (
        .sys_clk  (sys_clk),
        .csn_pin  (spi_csn_i),
        .sclk_pin (spi_sclk_i),
        .mosi_pin (spi_mosi_i),
        .csn_rise (csn_rise),
        .csn_fall (csn_fall),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .mosi     (mosi)
    );

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SH_W-2:0]   sh_in;
    logic [DATA_W-1:0] sh_out;
    logic [ADDR_W-1:0] addr;
    logic [TMR_W-1:0]  rd_tmr;
    logic              frame_done;   // single-word build: word handled, ignore the rest

    logic [SH_W-1:0]   sh_next;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              cmd_last;
    logic              data_last;

    assign sh_next   = {sh_in, mosi};
    assign cmd_addr  = sh_next[CMD_W-1 -: ADDR_W];
    assign addr_inc  = addr + ADDR_W'(1);
    assign cmd_last  = (bit_cnt == CNT_W'(CMD_W - 1));
    assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            sh_in         <= '0;
            sh_out        <= '0;
            addr          <= '0;
            rd_tmr        <= '0;
            frame_done    <= 1'b0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            reg_addr_o    <= '0;
            reg_wr_o      <= 1'b0;
            reg_wdata_o   <= '0;
            reg_rd_o      <= 1'b0;
            spi_err_o     <= 1'b0;
        end else begin
            reg_wr_o  <= 1'b0;
            reg_rd_o  <= 1'b0;
            spi_err_o <= 1'b0;
            if (csn_rise) begin
                // Ending on a word boundary is clean; mid-word is an abort.
                if (state != IDLE && bit_cnt != '0 && !frame_done)
                    spi_err_o <= 1'b1;
                state         <= IDLE;
                bit_cnt       <= '0;
                frame_done    <= 1'b0;
                spi_miso_o    <= 1'b0;
                spi_miso_oe_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (csn_fall) begin
                            state      <= CMD;
                            bit_cnt    <= '0;
                            frame_done <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            sh_in <= sh_next[SH_W-2:0];
                            if (cmd_last) begin
                                bit_cnt <= '0;
                                addr    <= cmd_addr;
                                if (sh_next[CMD_RNW_BIT]) begin
                                    state      <= RD_FETCH;
                                    reg_rd_o   <= 1'b1;
                                    reg_addr_o <= cmd_addr;
                                    rd_tmr     <= TMR_W'(RD_WAIT_MAX);
                                end else begin
                                    state <= WR_DATA;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclk_rise && !frame_done) begin
                            sh_in <= sh_next[SH_W-2:0];
                            if (data_last) begin
                                bit_cnt     <= '0;
                                reg_wr_o    <= 1'b1;
                                reg_addr_o  <= addr;
                                reg_wdata_o <= sh_next[DATA_W-1:0];
                                if (BURST) addr <= addr_inc;
                                else       frame_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    RD_FETCH: begin
                        if (reg_rvalid_i) begin
                            sh_out        <= reg_rdata_i;
                            state         <= RD_DATA;
                            spi_miso_oe_o <= 1'b1;
                        end else if (rd_tmr == '0) begin
                            sh_out        <= '0;
                            spi_err_o     <= 1'b1;
                            state         <= RD_DATA;
                            spi_miso_oe_o <= 1'b1;
                        end else begin
                            rd_tmr <= rd_tmr - TMR_W'(1);
                        end
                    end
                    RD_DATA: begin
                        if (!frame_done) begin
                            if (sclk_fall) begin
                                spi_miso_o <= sh_out[DATA_W-1];
                                sh_out     <= {sh_out[DATA_W-2:0], 1'b0};
                            end
                            if (sclk_rise) begin
                                if (data_last) begin
                                    bit_cnt <= '0;
                                    if (BURST) begin
                                        // Prefetch so the next MSB is ready at the following fall.
                                        addr       <= addr_inc;
                                        reg_addr_o <= addr_inc;
                                        reg_rd_o   <= 1'b1;
                                        rd_tmr     <= TMR_W'(RD_WAIT_MAX);
                                        state      <= RD_FETCH;
                                    end else begin
                                        frame_done    <= 1'b1;
                                        spi_miso_o    <= 1'b0;
                                        spi_miso_oe_o <= 1'b0;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + CNT_W'(1);
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
